// File: rtl/sseg_src_arbiter_if.sv
// Source/display bundle for sseg_src_arbiter: two requesting sources on one side,
// the shared univ_sseg value/valid on the other.
interface sseg_src_arbiter_if #(
    parameter int W = 14
);
    logic         req0;
    logic         req1;
    logic [W-1:0] data0;
    logic [W-1:0] data1;
    logic         gnt0;
    logic         gnt1;
    logic [W-1:0] cnt1;
    logic         valid;
    logic         sel;

    modport master (
        output req0, req1, data0, data1,
        input  gnt0, gnt1, cnt1, valid, sel
    );

    modport slave (
        input  req0, req1, data0, data1,
        output gnt0, gnt1, cnt1, valid, sel
    );
endinterface

// File: rtl/sseg_src_arbiter.sv
// Time-slicing arbiter sharing univ_sseg between two sources with a minimum tick-based dwell.
// Define SSEG_ARB_FIXED_PRIO_EN to give source 0 fixed priority instead of round robin.
//
// state | meaning
// IDLE  | no source owns the display, VALID low
// OWN0  | source 0 owns the display
// OWN1  | source 1 owns the display
module sseg_src_arbiter #(
    parameter int W        = 14,
    parameter int TICK_DIV = 25000000,
    parameter int DWELL    = 4
) (
    input logic              clk,
    input logic              rst_n,
    sseg_src_arbiter_if.slave bus
);
    localparam int TW  = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int DWW = $clog2(DWELL + 1);
    localparam logic [TW-1:0]  TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [DWW-1:0] DWELL_MAX = DWW'(DWELL);
    localparam logic [DWW-1:0] DWELL_PRE = DWW'(DWELL - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t         state, state_nxt;
    logic           last, last_nxt;
    logic [TW-1:0]  tick_cnt;
    logic           tick;
    logic [DWW-1:0] dwell_cnt, dwell_nxt;
    logic           dwell_sat;
    logic           expired;
    logic           gnt0_nxt, gnt1_nxt, valid_nxt;
    logic [W-1:0]   cnt1_nxt;

    // Free-running prescaler; grants never re-phase it.
    assign tick = (tick_cnt == TICK_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    // Expiry includes the tick that completes the dwell so the grant can hand over on that edge.
    assign dwell_sat = (dwell_cnt == DWELL_MAX);
    assign expired   = dwell_sat || (tick && (dwell_cnt == DWELL_PRE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            last      <= 1'b1;
            dwell_cnt <= '0;
            bus.gnt0  <= 1'b0;
            bus.gnt1  <= 1'b0;
            bus.cnt1  <= '0;
            bus.valid <= 1'b0;
            bus.sel   <= 1'b1;
        end else begin
            state     <= state_nxt;
            last      <= last_nxt;
            dwell_cnt <= dwell_nxt;
            bus.gnt0  <= gnt0_nxt;
            bus.gnt1  <= gnt1_nxt;
            bus.cnt1  <= cnt1_nxt;
            bus.valid <= valid_nxt;
            bus.sel   <= last_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        dwell_nxt = dwell_cnt;
        gnt0_nxt  = 1'b0;
        gnt1_nxt  = 1'b0;
        valid_nxt = 1'b0;
        cnt1_nxt  = '0;

        case (state)
            IDLE: begin
                if (bus.req0 && bus.req1) begin
`ifdef SSEG_ARB_FIXED_PRIO_EN
                    state_nxt = OWN0;
`else
                    state_nxt = last ? OWN0 : OWN1;
`endif
                end else if (bus.req0) begin
                    state_nxt = OWN0;
                end else if (bus.req1) begin
                    state_nxt = OWN1;
                end
            end
            OWN0: begin
                if (!bus.req0) begin
                    state_nxt = bus.req1 ? OWN1 : IDLE;
                end else begin
`ifndef SSEG_ARB_FIXED_PRIO_EN
                    if (expired && bus.req1) begin
                        state_nxt = OWN1;
                    end
`endif
                end
            end
            OWN1: begin
                if (!bus.req1) begin
                    state_nxt = bus.req0 ? OWN0 : IDLE;
                end else if (expired && bus.req0) begin
                    state_nxt = OWN0;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if ((state_nxt != state) && (state_nxt != IDLE)) begin
            dwell_nxt = '0;
            last_nxt  = (state_nxt == OWN1);
        end else if (state_nxt == IDLE) begin
            dwell_nxt = '0;
        end else if (tick && !dwell_sat) begin
            dwell_nxt = dwell_cnt + 1'b1;
        end

        case (state_nxt)
            OWN0: begin
                gnt0_nxt  = 1'b1;
                valid_nxt = 1'b1;
                cnt1_nxt  = bus.data0;
            end
            OWN1: begin
                gnt1_nxt  = 1'b1;
                valid_nxt = 1'b1;
                cnt1_nxt  = bus.data1;
            end
            default: begin
                gnt0_nxt  = 1'b0;
                gnt1_nxt  = 1'b0;
            end
        endcase
    end
endmodule
